router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
- Control block for the 1x3 router.
- Sequences writes of one incoming packet into one of three 16-deep output FIFOs, selected by the 2-bit address in the header byte.
- Produces per-FIFO write enables, the lfd_state header tag, and busy back-pressure to the source.
- Generates per-port soft_reset when a destination leaves valid data unread for TIMEOUT cycles.

Parameters:
TIMEOUT, 30, consecutive unread cycles before a port's soft_reset fires (2..2**CNT_W)
CNT_W, 5, width of each per-port timeout counter

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
pkt_valid  in  1  source has a valid byte this cycle
data_in  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
parity_done  in  1  datapath has registered the parity byte
low_pkt_valid  in  1  pkt_valid fell while FIFO was full
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
read_enb  in  3  destination read strobe per port
write_enb  out  3  one-hot FIFO write enable
soft_reset  out  3  per-port soft reset pulse
vld_out  out  3  per-port data-available
sel_full  out  1  fifo_full[addr_reg]
busy  out  1  stall source
detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes to datapath
bad_addr  out  1  address-3 packet flag, see Optional Feature

Behaviour:
- Reset (resetn=0 at edge): state=DECODE_ADDRESS, addr_reg=0, all counters=0, soft_reset=0. State decodes follow from DECODE_ADDRESS.
- Priority: resetn > soft_reset[addr_reg] (forces DECODE_ADDRESS next edge, any state) > normal transitions.
- DECODE_ADDRESS (detect_add=1, busy=0):
  - On pkt_valid with data_in!=3: addr_reg<=data_in.
  - Next state LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY.
  - data_in==3: stay.
- WAIT_TILL_EMPTY (busy=1): -> LOAD_FIRST_DATA when fifo_empty[addr_reg].
- LOAD_FIRST_DATA (lfd_state=1, busy=1): -> LOAD_DATA unconditionally.
- LOAD_DATA (ld_state=1, busy=0):
  - fifo_full[addr_reg] -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE (full_state=1, busy=1, no write): -> LOAD_AFTER_FULL when !fifo_full[addr_reg].
- LOAD_AFTER_FULL (laf_state=1, busy=1):
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY (busy=1): -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (rst_int_reg=1, busy=1): fifo_full[addr_reg] -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Write enables:
  - Internal write enable is 1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
  - write_enb[n] = that enable && addr_reg==n, combinational, never more than one hot.
- Other combinational outputs: vld_out[n] = ~fifo_empty[n]. sel_full = fifo_full[addr_reg].
- Timeout counter, per port n, each edge:
  - If !vld_out[n] or read_enb[n]: cnt<=0, soft_reset[n]<=0.
  - Else if cnt==TIMEOUT-1: cnt<=0, soft_reset[n]<=1.
  - Else cnt<=cnt+1, soft_reset[n]<=0.
  - Result: a one-cycle pulse after TIMEOUT consecutive unread edges; repeats every TIMEOUT cycles if still unread.
  - Counters are independent of the FSM and wrap only via the terminal clear.
- Undefined state encodings recover to DECODE_ADDRESS.

Optional Feature:
- Macro ROUTER_CTRL_BAD_ADDR_DROP_EN.
- Defined:
  - pkt_valid with data_in==3 in DECODE_ADDRESS -> DROP_PACKET (busy=0, all write_enb=0, bad_addr=1 while in state).
  - Stays in DROP_PACKET while pkt_valid; the first cycle with !pkt_valid (parity byte) -> DECODE_ADDRESS.
- Undefined: no DROP_PACKET state; address 3 leaves the FSM in DECODE_ADDRESS; bad_addr tied 0.

Test Plan:
- resetn=0 for 2 cycles mid-LOAD_DATA -> DECODE_ADDRESS, write_enb=000, soft_reset=000, busy=0, detect_add=1.
- Header addr=1, fifo_empty=111, 4 payload bytes, then pkt_valid=0 -> states DECODE, LFD, LD x4, LP, CPE, DECODE. write_enb=010 for 6 cycles, busy=1 in LFD/LP/CPE.
- Header addr=2 with fifo_empty[2]=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1, write_enb=000. Empty rises -> LFD on next edge.
- In LD addr=0, fifo_full[0]=1 for 3 cycles -> FIFO_FULL_STATE, write_enb=000. Release with low_pkt_valid=1 -> LAF then LP, write_enb=001 in both.
- vld_out[2]=1, read_enb[2]=0 for 30 edges -> soft_reset[2]=1 for exactly one cycle, FSM (addr_reg=2) -> DECODE_ADDRESS. Read at edge 29 -> no pulse.
- With ROUTER_CTRL_BAD_ADDR_DROP_EN: header addr=3, 3 bytes -> bad_addr=1, write_enb=000 throughout, DECODE 1 cycle after pkt_valid falls. Without the macro: FSM stays in DECODE_ADDRESS.

Source files
------------

// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : router_ctrl
//  Purpose  : Control block for the 1x3 router. Decodes the 2-bit header
//             address, sequences writes of one packet into the selected
//             16-deep output FIFO, tags the header byte (lfd_state), stalls
//             the source (busy) and raises a per-port soft_reset pulse when
//             a destination leaves valid data unread for TIMEOUT cycles.
//  Ports    : clk, resetn (sync, active low)
//             pkt_valid, data_in[1:0], parity_done, low_pkt_valid  - source/datapath
//             fifo_full[2:0], fifo_empty[2:0], read_enb[2:0]       - FIFO side
//             write_enb[2:0], soft_reset[2:0], vld_out[2:0]        - per port
//             sel_full, busy, detect_add, lfd_state, ld_state,
//             laf_state, full_state, rst_int_reg, bad_addr         - decodes
//  Options  : `define ROUTER_CTRL_BAD_ADDR_DROP_EN adds a DROP_PACKET state
//             that swallows address-3 packets and flags them on bad_addr.
//  Revision : 1.0 - initial release
// ============================================================================
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic [2:0] soft_reset,
    output logic [2:0] vld_out,
    output logic       sel_full,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       bad_addr
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        WAIT_TILL_EMPTY    = 4'd1,
        LOAD_FIRST_DATA    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        LOAD_PARITY        = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_term = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;
    logic       w_load_addr;
    logic       w_we;

    // Padded to four entries so an address index of 3 stays in range.
    logic [3:0] w_full_ext;
    logic [3:0] w_empty_ext;

    assign w_full_ext  = {1'b0, fifo_full};
    assign w_empty_ext = {1'b0, fifo_empty};
    assign vld_out     = ~fifo_empty;
    assign sel_full    = w_full_ext[r_addr];
    assign write_enb   = w_we ? (3'b001 << r_addr) : 3'b000;

    // ------------------------------------------------------------------
    // State / address register. A soft reset on the port being written
    // abandons the packet and overrides any normal transition.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else if (soft_reset[r_addr]) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
            if (w_load_addr) begin
                r_addr <= data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state decodes.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load_addr  = 1'b0;
        w_we         = 1'b0;
        busy         = 1'b0;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
        bad_addr     = 1'b0;

        case (r_state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (pkt_valid && (data_in != 2'd3)) begin
                    w_load_addr  = 1'b1;
                    w_next_state = w_empty_ext[data_in] ? LOAD_FIRST_DATA
                                                        : WAIT_TILL_EMPTY;
                end
`ifdef ROUTER_CTRL_BAD_ADDR_DROP_EN
                else if (pkt_valid) begin
                    w_next_state = DROP_PACKET;
                end
`endif
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (w_empty_ext[r_addr]) begin
                    w_next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                busy         = 1'b1;
                lfd_state    = 1'b1;
                w_we         = 1'b1;
                w_next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state = 1'b1;
                w_we     = 1'b1;
                if (w_full_ext[r_addr]) begin
                    w_next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                busy       = 1'b1;
                full_state = 1'b1;
                if (!w_full_ext[r_addr]) begin
                    w_next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                busy      = 1'b1;
                laf_state = 1'b1;
                w_we      = 1'b1;
                if (parity_done) begin
                    w_next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end else begin
                    w_next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                busy         = 1'b1;
                w_we         = 1'b1;
                w_next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                busy         = 1'b1;
                rst_int_reg  = 1'b1;
                w_next_state = w_full_ext[r_addr] ? FIFO_FULL_STATE
                                                  : DECODE_ADDRESS;
            end
`ifdef ROUTER_CTRL_BAD_ADDR_DROP_EN
            DROP_PACKET: begin
                bad_addr = 1'b1;
                // The first idle cycle carries the parity byte; it is
                // swallowed along with the rest of the packet.
                if (!pkt_valid) begin
                    w_next_state = DECODE_ADDRESS;
                end
            end
`endif
            default: begin
                w_next_state = DECODE_ADDRESS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-port unread timeout. The counter clears on its terminal count,
    // so a port that stays unread pulses once every TIMEOUT cycles.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
        logic [CNT_W-1:0] r_cnt;
        logic             r_pulse;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else if (!vld_out[gi] || read_enb[gi]) begin
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else if (r_cnt == c_cnt_term) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + c_cnt_one;
                r_pulse <= 1'b0;
            end
        end

        assign soft_reset[gi] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_ctrl
//  Purpose  : Self-checking bench for router_ctrl. A behavioural model of the
//             packet sequencing and per-port unread timeout tracks the DUT
//             and is compared every cycle; directed packets pin the model
//             with literal expectations, then randomized traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_ctrl;

    localparam int TIMEOUT = 30;
    localparam int CNT_W   = 5;

    // Model state names (independent of the DUT encoding).
    localparam int S_DEC  = 0;
    localparam int S_WTE  = 1;
    localparam int S_LFD  = 2;
    localparam int S_LD   = 3;
    localparam int S_FULL = 4;
    localparam int S_LAF  = 5;
    localparam int S_LP   = 6;
    localparam int S_CPE  = 7;
    localparam int S_DROP = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic [2:0] soft_reset;
    logic [2:0] vld_out;
    logic       sel_full;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       bad_addr;

    int n_chk  = 0;
    int n_fail = 0;

    router_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .read_enb     (read_enb),
        .write_enb    (write_enb),
        .soft_reset   (soft_reset),
        .vld_out      (vld_out),
        .sel_full     (sel_full),
        .busy         (busy),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .bad_addr     (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int         m_st;
    logic [1:0] m_addr;
    int         m_unread [3];
    logic [2:0] m_sr;
    bit         m_valid = 1'b0;

    function automatic int next_unread(input int n);
        return (fifo_empty[n] || read_enb[n]) ? 0 : m_unread[n] + 1;
    endfunction

    function automatic int model_next();
        case (m_st)
            S_DEC: begin
                if (pkt_valid && data_in != 2'd3)
                    return fifo_empty[data_in] ? S_LFD : S_WTE;
`ifdef ROUTER_CTRL_BAD_ADDR_DROP_EN
                if (pkt_valid) return S_DROP;
`endif
                return S_DEC;
            end
            S_WTE:  return fifo_empty[m_addr] ? S_LFD : S_WTE;
            S_LFD:  return S_LD;
            S_LD:   return fifo_full[m_addr] ? S_FULL : (pkt_valid ? S_LD : S_LP);
            S_FULL: return fifo_full[m_addr] ? S_FULL : S_LAF;
            S_LAF:  return parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
            S_LP:   return S_CPE;
            S_CPE:  return fifo_full[m_addr] ? S_FULL : S_DEC;
            S_DROP: return pkt_valid ? S_DROP : S_DEC;
            default: return S_DEC;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_st    <= S_DEC;
            m_addr  <= 2'd0;
            m_sr    <= 3'b000;
            m_valid <= 1'b1;
            for (int n = 0; n < 3; n++) m_unread[n] <= 0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                m_sr[n]     <= (next_unread(n) == TIMEOUT);
                m_unread[n] <= (next_unread(n) == TIMEOUT) ? 0 : next_unread(n);
            end
            if (m_sr[m_addr]) begin
                m_st <= S_DEC;
            end else begin
                m_st <= model_next();
                if (m_st == S_DEC && pkt_valid && data_in != 2'd3) m_addr <= data_in;
            end
        end
    end

    function automatic logic [2:0] exp_we();
        logic [2:0] v;
        v = 3'b000;
        if (m_st == S_LFD || m_st == S_LD || m_st == S_LAF || m_st == S_LP) v[m_addr] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_busy();
        return (m_st == S_WTE || m_st == S_LFD || m_st == S_FULL ||
                m_st == S_LAF || m_st == S_LP || m_st == S_CPE);
    endfunction

    function automatic logic exp_bad();
`ifdef ROUTER_CTRL_BAD_ADDR_DROP_EN
        return (m_st == S_DROP);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_write_enb",   write_enb,   exp_we());
            check("m_soft_reset",  soft_reset,  m_sr);
            check("m_vld_out",     vld_out,     ~fifo_empty);
            check("m_sel_full",    {2'b0, sel_full},    {2'b0, fifo_full[m_addr]});
            check("m_busy",        {2'b0, busy},        {2'b0, exp_busy()});
            check("m_detect_add",  {2'b0, detect_add},  {2'b0, m_st == S_DEC});
            check("m_lfd_state",   {2'b0, lfd_state},   {2'b0, m_st == S_LFD});
            check("m_ld_state",    {2'b0, ld_state},    {2'b0, m_st == S_LD});
            check("m_laf_state",   {2'b0, laf_state},   {2'b0, m_st == S_LAF});
            check("m_full_state",  {2'b0, full_state},  {2'b0, m_st == S_FULL});
            check("m_rst_int_reg", {2'b0, rst_int_reg}, {2'b0, m_st == S_CPE});
            check("m_bad_addr",    {2'b0, bad_addr},    {2'b0, exp_bad()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int rd_div;
        int flip_div;

        resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
        low_pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;

        // Start a packet, then reset mid-LOAD_DATA.
        resetn = 1'b0; tick(); resetn = 1'b1;
        pkt_valid = 1'b1; data_in = 2'd1; tick(); tick();
        check("pre_reset_ld", {2'b0, ld_state}, 3'b001);
        resetn = 1'b0; tick(); tick();
        check("rst_detect_add", {2'b0, detect_add}, 3'b001);
        check("rst_busy",       {2'b0, busy},       3'b000);
        check("rst_write_enb",  write_enb,          3'b000);
        check("rst_soft_reset", soft_reset,         3'b000);
        resetn = 1'b1; pkt_valid = 1'b0; tick();

        // Address 1, FIFO empty, 4 payload cycles.
        pkt_valid = 1'b1; data_in = 2'd1; tick();
        check("a1_lfd",  {2'b0, lfd_state}, 3'b001);
        check("a1_busy", {2'b0, busy},      3'b001);
        check("a1_we",   write_enb,         3'b010);
        data_in = 2'd0; tick();
        check("a1_ld_busy", {2'b0, busy}, 3'b000);
        check("a1_ld_we",   write_enb,    3'b010);
        tick(); tick(); tick();
        check("a1_ld4", {2'b0, ld_state}, 3'b001);
        pkt_valid = 1'b0; tick();
        check("a1_lp_we",   write_enb,    3'b010);
        check("a1_lp_busy", {2'b0, busy}, 3'b001);
        tick();
        check("a1_cpe",    {2'b0, rst_int_reg}, 3'b001);
        check("a1_cpe_we", write_enb,           3'b000);
        tick();
        check("a1_done", {2'b0, detect_add}, 3'b001);

        // Address 2 with a non-empty FIFO: wait, then load.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011; read_enb = 3'b100; tick();
        pkt_valid = 1'b0; tick(); tick(); tick(); tick();
        check("a2_wte_busy", {2'b0, busy}, 3'b001);
        check("a2_wte_we",   write_enb,    3'b000);
        fifo_empty = 3'b111; tick();
        check("a2_lfd", {2'b0, lfd_state}, 3'b001);
        read_enb = 3'b000; tick(); tick(); tick(); tick();
        check("a2_done", {2'b0, detect_add}, 3'b001);

        // Address 0, FIFO fills during LOAD_DATA.
        pkt_valid = 1'b1; data_in = 2'd0; tick(); tick();
        fifo_full = 3'b001; tick();
        check("a0_full",    {2'b0, full_state}, 3'b001);
        check("a0_full_we", write_enb,          3'b000);
        tick(); tick();
        fifo_full = 3'b000; low_pkt_valid = 1'b1; pkt_valid = 1'b0; tick();
        check("a0_laf",    {2'b0, laf_state}, 3'b001);
        check("a0_laf_we", write_enb,         3'b001);
        tick();
        check("a0_lp_we", write_enb, 3'b001);
        low_pkt_valid = 1'b0; tick(); tick();
        check("a0_done", {2'b0, detect_add}, 3'b001);

        // Port 2 left unread for TIMEOUT edges while it is being written.
        pkt_valid = 1'b1; data_in = 2'd2; tick();
        fifo_empty = 3'b011;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("to_no_pulse_early", soft_reset, 3'b000);
        tick();
        check("to_pulse",    soft_reset,        3'b100);
        check("to_pulse_ld", {2'b0, ld_state},  3'b001);
        tick();
        check("to_pulse_end", soft_reset,         3'b000);
        check("to_fsm_dec",   {2'b0, detect_add}, 3'b001);
        pkt_valid = 1'b0; read_enb = 3'b100; tick(); read_enb = 3'b000;
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        read_enb = 3'b100; tick(); read_enb = 3'b000; tick();
        check("to_read_saves", soft_reset, 3'b000);
        fifo_empty = 3'b111; tick();

        // Address 3 packet: three bytes then the parity cycle.
        pkt_valid = 1'b1; data_in = 2'd3; tick();
`ifdef ROUTER_CTRL_BAD_ADDR_DROP_EN
        check("a3_bad",  {2'b0, bad_addr}, 3'b001);
        check("a3_busy", {2'b0, busy},     3'b000);
`else
        check("a3_stay", {2'b0, detect_add}, 3'b001);
        check("a3_bad0", {2'b0, bad_addr},   3'b000);
`endif
        check("a3_we", write_enb, 3'b000);
        tick(); tick();
        check("a3_we_late", write_enb, 3'b000);
        pkt_valid = 1'b0; tick();
        check("a3_done", {2'b0, detect_add}, 3'b001);

        // Randomized traffic: busy phase then a sparse-read phase that lets
        // timeouts fire.
        for (int c = 0; c < 6000; c++) begin
            rd_div   = (c < 3000) ? 4 : 80;
            flip_div = (c < 3000) ? 8 : 60;
            resetn        = ($urandom_range(0, 399) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, flip_div - 1) == 0) fifo_empty[n] = ~fifo_empty[n];
                if ($urandom_range(0, 7) == 0)            fifo_full[n]  = ~fifo_full[n];
                read_enb[n] = ($urandom_range(0, rd_div - 1) == 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
